// File: rtl/input_harness_sched_pkg.sv
// Shared types and constants for the input-harness scheduler and its helpers.
package input_harness_pkg;

  localparam int DEF_WORD_W  = 8;
  localparam int DEF_N_PORTS = 4;
  localparam int DROPCNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } sched_state_t;

endpackage

// File: rtl/input_harness_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// rr_ptr, wrapping around, and reports it as one-hot grant plus index.
module rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] port_req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  logic [PTR_W-1:0] idx_s;

  // Scan requesters starting at rr_ptr; the first hit wins.
  always_comb begin
    grant     = {N_PORTS{1'b0}};
    grant_idx = {PTR_W{1'b0}};
    any       = 1'b0;
    idx_s     = {PTR_W{1'b0}};
    for (int k = 0; k < N_PORTS; k++) begin
      idx_s = PTR_W'((int'(rr_ptr) + k) % N_PORTS);
      if (!any && port_req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        any          = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/input_harness_sched.sv
// Input-harness scheduler: deserializes an LSB-first bit stream into words and
// hands each word to one requesting port via a locked round-robin grant.
// Optional drop counter enabled by defining INPUT_HARNESS_SCHED_DROPCNT_EN.
module input_harness_sched
  import input_harness_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int N_PORTS = DEF_N_PORTS
) (
  input  logic               fast_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_bit,
  input  logic [N_PORTS-1:0] port_req,
  input  logic [N_PORTS-1:0] port_ready,
  output logic [N_PORTS-1:0] port_valid,
  output logic [WORD_W-1:0]  port_data,
  output logic               overflow,
  output logic               busy
`ifdef INPUT_HARNESS_SCHED_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0] drop_count
`endif
);

  localparam int PTR_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0]  shift_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [WORD_W-1:0]  buf_r;
  logic               buf_valid_r;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   grant_idx_r;
  logic [N_PORTS-1:0] grant_r;
  logic               overflow_r;
  sched_state_t       state_r;

  logic [WORD_W-1:0]  word_s;
  logic               complete_s;
  logic               handshake_s;
  logic               accept_s;
  logic               drop_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [N_PORTS-1:0] arb_grant_s;
  logic [PTR_W-1:0]   arb_idx_s;
  logic               arb_any_s;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_arb (
    .port_req  (port_req),
    .rr_ptr    (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  // Word completion, handshake and buffer-accept decisions for this cycle.
  always_comb begin
    word_s      = {in_bit, shift_r[WORD_W-1:1]};
    complete_s  = en && (bit_cnt_r == CNT_W'(WORD_W - 1));
    handshake_s = (state_r == GRANT) && ((grant_r & port_ready) != {N_PORTS{1'b0}});
    // A word may replace the buffer in the same cycle the old one is taken.
    accept_s    = complete_s && (!buf_valid_r || handshake_s);
    drop_s      = complete_s && !accept_s;
    if (grant_idx_r == PTR_W'(N_PORTS - 1)) begin
      next_ptr_s = {PTR_W{1'b0}};
    end else begin
      next_ptr_s = grant_idx_r + PTR_W'(1);
    end
  end

  // Deserializer: shift LSB-first, never stalls regardless of buffer state.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      shift_r   <= {WORD_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      shift_r <= word_s;
      if (complete_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Scheduler FSM: buffer fill, arbitration, locked grant and sticky overflow.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state_r     <= IDLE;
      buf_r       <= {WORD_W{1'b0}};
      buf_valid_r <= 1'b0;
      rr_ptr_r    <= {PTR_W{1'b0}};
      grant_r     <= {N_PORTS{1'b0}};
      grant_idx_r <= {PTR_W{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            buf_r       <= word_s;
            buf_valid_r <= 1'b1;
            state_r     <= ARB;
          end
        end
        ARB: begin
          if (arb_any_s) begin
            grant_r     <= arb_grant_s;
            grant_idx_r <= arb_idx_s;
            state_r     <= GRANT;
          end
        end
        GRANT: begin
          // Grant stays locked until the granted port itself is ready.
          if (handshake_s) begin
            grant_r  <= {N_PORTS{1'b0}};
            rr_ptr_r <= next_ptr_s;
            if (accept_s) begin
              buf_r   <= word_s;
              state_r <= ARB;
            end else begin
              // Clearing the buffer keeps port_data at zero while idle.
              buf_r       <= {WORD_W{1'b0}};
              buf_valid_r <= 1'b0;
              state_r     <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          buf_r       <= {WORD_W{1'b0}};
          buf_valid_r <= 1'b0;
          grant_r     <= {N_PORTS{1'b0}};
        end
      endcase
    end
  end

`ifdef INPUT_HARNESS_SCHED_DROPCNT_EN
  logic [DROPCNT_W-1:0] drop_cnt_r;

  // Saturating count of dropped words.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      drop_cnt_r <= {DROPCNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_r != {DROPCNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + DROPCNT_W'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_count = drop_cnt_r;
`endif

  assign port_valid = grant_r;
  assign port_data  = buf_r;
  assign overflow   = overflow_r;
  assign busy       = buf_valid_r;

endmodule

// File: tb/tb_input_harness_sched.sv
// Self-checking bench for input_harness_sched: table of words with expected
// round-robin destination, plus hand sequences for timing, locked grant,
// overflow, enable gaps and reset mid-grant.
module tb_input_harness_sched;
  import input_harness_pkg::*;

  localparam int WORD_W  = 8;
  localparam int N_PORTS = 4;

  logic              fast_clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              in_bit = 1'b0;
  logic [N_PORTS-1:0] port_req = 4'b0000;
  logic [N_PORTS-1:0] port_ready = 4'b0000;
  logic [N_PORTS-1:0] port_valid;
  logic [WORD_W-1:0]  port_data;
  logic              overflow;
  logic              busy;
`ifdef INPUT_HARNESS_SCHED_DROPCNT_EN
  logic [DROPCNT_W-1:0] drop_count;
`endif

  input_harness_sched #(.WORD_W(WORD_W), .N_PORTS(N_PORTS)) dut (
    .fast_clk   (fast_clk),
    .rst        (rst),
    .en         (en),
    .in_bit     (in_bit),
    .port_req   (port_req),
    .port_ready (port_ready),
    .port_valid (port_valid),
    .port_data  (port_data),
    .overflow   (overflow),
    .busy       (busy)
`ifdef INPUT_HARNESS_SCHED_DROPCNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    logic [7:0] data;
    int         port;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] req;
    int         port;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit gapped);
    for (int i = 0; i < 8; i++) begin
      @(negedge fast_clk);
      en = 1'b1;
      in_bit = w[i];
      if (gapped) begin
        @(negedge fast_clk);
        en = 1'b0;
      end
    end
    @(negedge fast_clk);
    en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge fast_clk);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected word.
  always @(negedge fast_clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if ($countones(port_valid) > 1) begin
        nvec++;
        nerr++;
        $display("FAIL onehot: got %b expected at most one bit", port_valid);
      end
      if ((port_valid & port_ready) != 4'b0000) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_handshake: got valid %b data %h expected none", port_valid, port_data);
        end else begin
          e = sb.pop_front();
          chk("sb_grant", 32'(port_valid), 32'(4'b0001 << e.port));
          chk("sb_data", 32'(port_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Starting rr_ptr is 1 after the first hand-written word to port 0.
    vecs[0] = '{8'hA5, 4'b1111, 1};
    vecs[1] = '{8'h3C, 4'b1111, 2};
    vecs[2] = '{8'hFF, 4'b1111, 3};
    vecs[3] = '{8'h00, 4'b1111, 0};
    vecs[4] = '{8'h81, 4'b0001, 0};
    vecs[5] = '{8'h7E, 4'b1000, 3};
    vecs[6] = '{8'h12, 4'b0110, 1};
    vecs[7] = '{8'h99, 4'b0011, 0};
    vecs[8] = '{8'h55, 4'b1100, 2};

    // Reset state
    repeat (2) @(negedge fast_clk);
    rst = 1'b0;
    chk("rst_valid", 32'(port_valid), 32'h0);
    chk("rst_data", 32'(port_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
`ifdef INPUT_HARNESS_SCHED_DROPCNT_EN
    chk("rst_dcnt", 32'(drop_count), 32'h0);
`endif

    // Serial word 1,0,1,1,0,0,1,0 -> 8'h4D, valid two cycles after last bit
    port_req = 4'b0001;
    port_ready = 4'b1111;
    sb.push_back('{8'h4D, 0});
    send_word(8'h4D, 1'b0);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_early", 32'(port_valid), 32'h0);
    @(negedge fast_clk);
    chk("t1_valid", 32'(port_valid), 32'h1);
    chk("t1_data", 32'(port_data), 32'h4D);
    @(negedge fast_clk);
    chk("t1_onecycle", 32'(port_valid), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_ovf", 32'(overflow), 32'h0);
    wait_drain("t1_drain");

    // Table: round-robin destinations
    for (int v = 0; v < 9; v++) begin
      port_req = vecs[v].req;
      sb.push_back('{vecs[v].data, vecs[v].port});
      send_word(vecs[v].data, 1'b0);
      wait_drain("rr_drain");
    end

    // Locked grant: rr_ptr is 3, only port 2 requests
    port_ready = 4'b0000;
    port_req = 4'b0100;
    sb.push_back('{8'hC3, 2});
    send_word(8'hC3, 1'b0);
    @(negedge fast_clk);
    chk("lock_grant", 32'(port_valid), 32'h4);
    port_req = 4'b0000;
    port_ready = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge fast_clk);
      chk("lock_hold", 32'(port_valid), 32'h4);
      chk("lock_data", 32'(port_data), 32'hC3);
    end
    port_ready = 4'b0100;
    wait_drain("lock_drain");
    @(negedge fast_clk);
    chk("lock_release", 32'(port_valid), 32'h0);
    port_ready = 4'b1111;

    // Overflow: rr_ptr is 3, no requests, two words
    port_req = 4'b0000;
    sb.push_back('{8'h5A, 3});
    send_word(8'h5A, 1'b0);
    chk("ovf_busy", 32'(busy), 32'h1);
    chk("ovf_novalid", 32'(port_valid), 32'h0);
    chk("ovf_clear", 32'(overflow), 32'h0);
    send_word(8'h6B, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_keep", 32'(port_data), 32'h5A);
    chk("ovf_busy2", 32'(busy), 32'h1);
`ifdef INPUT_HARNESS_SCHED_DROPCNT_EN
    chk("dcnt_one", 32'(drop_count), 32'h1);
    @(negedge fast_clk);
    force dut.drop_cnt_r = 16'hFFFD;
    @(negedge fast_clk);
    release dut.drop_cnt_r;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    chk("dcnt_sat", 32'(drop_count), 32'hFFFF);
`endif
    port_req = 4'b1111;
    wait_drain("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Reset, then gapped enable (one bit every other cycle)
    @(negedge fast_clk);
    rst = 1'b1;
    @(negedge fast_clk);
    rst = 1'b0;
    chk("rst2_ovf", 32'(overflow), 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
`ifdef INPUT_HARNESS_SCHED_DROPCNT_EN
    chk("rst2_dcnt", 32'(drop_count), 32'h0);
`endif
    port_req = 4'b0010;
    sb.push_back('{8'h96, 1});
    send_word(8'h96, 1'b1);
    wait_drain("gap_drain");

    // Reset mid-GRANT with a partial word in the shifter
    port_ready = 4'b0000;
    port_req = 4'b0001;
    send_word(8'hE7, 1'b0);
    @(negedge fast_clk);
    chk("mid_grant", 32'(port_valid), 32'h1);
    chk("mid_data", 32'(port_data), 32'hE7);
    for (int k = 0; k < 3; k++) begin
      @(negedge fast_clk);
      en = 1'b1;
      in_bit = 1'b1;
    end
    @(negedge fast_clk);
    en = 1'b0;
    rst = 1'b1;
    @(negedge fast_clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(port_valid), 32'h0);
    chk("mid_rst_data", 32'(port_data), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ovf", 32'(overflow), 32'h0);
    port_ready = 4'b1111;
    sb.push_back('{8'h3A, 0});
    send_word(8'h3A, 1'b0);
    wait_drain("post_rst_drain");
    repeat (3) @(negedge fast_clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/input_harness_sched.md
Name: input_harness_sched

Overview:
- Controller that turns a synchronized serial harness bit stream into WORD_W-bit words and shares them between N_PORTS DUT input consumers.
- Sits after the pin-crossing/shift stage of the synthesis input harness, in the fast clock domain.
- Deserializes LSB-first, then round-robin arbitrates each finished word to one requesting port using a valid/ready handshake.
- Detects and flags words lost when the single output buffer is still occupied.

Parameters:
- WORD_W, 8, bits per deserialized word (>=2).
- N_PORTS, 4, number of consumer ports (>=2, power of two not required).
- PTR_W, $clog2(N_PORTS), width of the round-robin pointer (derived; not to be overridden).

Ports:
- fast_clk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample in_bit this cycle.
- in_bit  in  1  serial data bit, already synchronized to fast_clk.
- port_req  in  N_PORTS  port i wants a word.
- port_ready  in  N_PORTS  port i accepts this cycle.
- port_valid  out  N_PORTS  one-hot grant; word offered to port i.
- port_data  out  WORD_W  shared word bus, meaningful while any port_valid is high.
- overflow  out  1  sticky: at least one word has been dropped.
- busy  out  1  buffer holds an undelivered word.

Behaviour:
- Reset (rst=1 at a clock edge): shift_reg=0, bit_cnt=0, buf=0, buf_valid=0, rr_ptr=0, state=IDLE. Outputs: port_valid=0, port_data=0, overflow=0, busy=0. Reset mid-handshake discards any pending word.
- Deserializer:
  - On en=1: shift_reg <= {in_bit, shift_reg[WORD_W-1:1]}.
  - bit_cnt increments modulo WORD_W. The first sampled bit lands at bit 0 of the word.
  - en=0: shift_reg and bit_cnt hold.
- Word completion: en=1 && bit_cnt==WORD_W-1. The completed word is {in_bit, shift_reg[WORD_W-1:1]}.
  - If buf_valid=0, or the buffer is handshaking this same cycle: buf <= word, buf_valid <= 1.
  - Otherwise the word is dropped and overflow <= 1. overflow stays set until reset.
  - The deserializer never stalls.
- FSM states:
  - IDLE (buf empty): on completion, go to ARB.
  - ARB (buf full, no grant):
    - If port_req != 0, pick the first requester scanning upward from rr_ptr with wrap-around, register it as the one-hot grant, and go to GRANT.
    - If port_req == 0, stay in ARB.
  - GRANT: port_valid = registered grant and port_data = buf.
    - The grant is locked. It is held stable until port_ready of the granted port is high, even if port_req drops. port_ready on other ports is ignored.
    - On handshake: rr_ptr <= grant index + 1, wrapping at N_PORTS to 0.
    - If a new word completes the same cycle, go to ARB with the new word; else go to IDLE with buf_valid=0.
- Latency: completion at cycle t gives buf_valid at t+1, and port_valid at t+2 if a request is present at t+1. Minimum word throughput is one per WORD_W cycles; the handshake takes 3 cycles, so no overflow occurs if ready is prompt and WORD_W>=3.
- busy = buf_valid.
- port_data = buf when busy, else 0.
- port_valid is never more than one-hot.

Optional Feature:
- Macro INPUT_HARNESS_SCHED_DROPCNT_EN.
  - When defined: adds output drop_count [15:0]. It increments on every dropped word, saturates at 16'hFFFF, and resets to 0.
  - When undefined: no port and no counter logic. overflow alone reports loss.

Decomposition:
- Shared package input_harness_pkg:
  - typedef sched_state_t {IDLE, ARB, GRANT}.
  - Constant DROPCNT_W=16.
  - Default WORD_W and N_PORTS constants.
- One sub-module: rr_arbiter (port_req, rr_ptr -> one-hot grant, grant index, any). Purely combinational, reusable by the output-side harness.

Test Plan:
- Serial word: reset, N_PORTS=4, port_req=4'b0001, port_ready=1, shift bits 1,0,1,1,0,0,1,0 with en=1 -> port_valid=4'b0001 with port_data=8'h4D two cycles after the last bit, for exactly one cycle; overflow=0.
- Round-robin: port_req=4'b1111, ready=1, send 5 words -> grants go to ports 0,1,2,3,0 in order.
- Locked grant: grant port 2, then drop port_req[2] with port_ready=0 for 10 cycles -> port_valid stays 4'b0100 with data unchanged, port_ready[1]=1 has no effect; ready[2]=1 then completes the handshake.
- Overflow: port_req=0, send 2 words -> the first word is held with busy=1; the second word is dropped, overflow=1, and drop_count=1 under the macro; a later grant delivers the first word.
- en gaps and reset: toggle en 0/1 every cycle, giving one word per 16 cycles with the correct value; assert rst mid-GRANT -> next cycle all outputs 0, and the next word starts from bit 0.
- Drop counter saturation: under the macro, force drop_count near 16'hFFFF and drop 3 more words -> counter saturates at 16'hFFFF.
